// File: rtl/class_result_unit_if.sv
// Request/result bundle for class_result_unit. The margin signal is present only
// when CLASS_RESULT_MARGIN_EN is defined.
interface class_result_unit_if #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 4
);
  localparam int IDX_W  = $clog2(NUM_CLASSES);
  localparam int COST_W = 2*SCORE_W + $clog2(NUM_CLASSES);

  logic                           start;
  logic [NUM_CLASSES*SCORE_W-1:0] scores;
  logic                           label_valid;
  logic [NUM_CLASSES-1:0]         expected_label;
  logic                           busy;
  logic                           done;
  logic [IDX_W-1:0]               detected_class;
  logic [SCORE_W-1:0]             max_score;
  logic [COST_W-1:0]              cost;
  logic                           cost_valid;
`ifdef CLASS_RESULT_MARGIN_EN
  logic [SCORE_W-1:0]             margin;
`endif

  modport master (
    output start, scores, label_valid, expected_label,
    input  busy, done, detected_class, max_score, cost, cost_valid
`ifdef CLASS_RESULT_MARGIN_EN
    , input margin
`endif
  );

  modport slave (
    input  start, scores, label_valid, expected_label,
    output busy, done, detected_class, max_score, cost, cost_valid
`ifdef CLASS_RESULT_MARGIN_EN
    , output margin
`endif
  );
endinterface

// File: rtl/class_result_unit.sv
// Sequential argmax + squared-error cost over NUM_CLASSES scores, one class per cycle.
// Optional runner-up margin output enabled by defining CLASS_RESULT_MARGIN_EN.
module class_result_unit #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  class_result_unit_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_CLASSES);
  localparam int COST_W = 2*SCORE_W + $clog2(NUM_CLASSES);
  localparam int SQ_W   = 2*SCORE_W;
  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(NUM_CLASSES-1);
  localparam logic [SCORE_W-1:0] S_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                         r_state, w_next;
  logic [NUM_CLASSES*SCORE_W-1:0] r_scores;
  logic [NUM_CLASSES-1:0]         r_label;
  logic                           r_lv;
  logic [IDX_W-1:0]               r_cnt;
  logic [SCORE_W-1:0]             r_best;
  logic [IDX_W-1:0]               r_best_idx;
  logic [COST_W-1:0]              r_acc;
  logic [IDX_W-1:0]               r_det;
  logic [SCORE_W-1:0]             r_max;
  logic [COST_W-1:0]              r_cost;
  logic                           r_cv;
  logic                           r_done;
`ifdef CLASS_RESULT_MARGIN_EN
  logic [SCORE_W-1:0]             r_second;
  logic [SCORE_W-1:0]             r_margin;
`endif

  logic [SCORE_W-1:0] w_cur;
  logic               w_lbl;
  logic [SCORE_W-1:0] w_diff;
  logic [SQ_W-1:0]    w_sq;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SCAN;
      S_SCAN:  if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Select the class addressed by the counter and form its squared error.
  always_comb begin
    w_cur = '0;
    w_lbl = 1'b0;
    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
      if (IDX_W'(i) == r_cnt) begin
        w_cur = r_scores[i*SCORE_W +: SCORE_W];
        w_lbl = r_label[i];
      end
    end
    w_diff = w_lbl ? (S_MAX - w_cur) : w_cur;
    w_sq   = SQ_W'(w_diff) * SQ_W'(w_diff);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_scores   <= '0;
      r_label    <= '0;
      r_lv       <= 1'b0;
      r_cnt      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_acc      <= '0;
      r_det      <= '0;
      r_max      <= '0;
      r_cost     <= '0;
      r_cv       <= 1'b0;
      r_done     <= 1'b0;
`ifdef CLASS_RESULT_MARGIN_EN
      r_second   <= '0;
      r_margin   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_scores   <= bus.scores;
            r_label    <= bus.expected_label;
            r_lv       <= bus.label_valid;
            r_cnt      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_acc      <= '0;
`ifdef CLASS_RESULT_MARGIN_EN
            r_second   <= '0;
`endif
          end
        end
        S_SCAN: begin
          r_cnt <= r_cnt + IDX_W'(1);
          r_acc <= r_acc + COST_W'(w_sq);
          // Starting best at 0 is safe: scores are unsigned, so class 0 still wins an all-zero scan.
          if (w_cur > r_best) begin
            r_best     <= w_cur;
            r_best_idx <= r_cnt;
`ifdef CLASS_RESULT_MARGIN_EN
            r_second   <= r_best;
          end else if (w_cur > r_second) begin
            r_second   <= w_cur;
`endif
          end
        end
        S_DONE: begin
          r_det  <= r_best_idx;
          r_max  <= r_best;
          r_cost <= r_lv ? r_acc : '0;
          r_cv   <= r_lv;
          r_done <= 1'b1;
`ifdef CLASS_RESULT_MARGIN_EN
          r_margin <= r_best - r_second;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = r_done;
  assign bus.detected_class = r_det;
  assign bus.max_score      = r_max;
  assign bus.cost           = r_cost;
  assign bus.cost_valid     = r_cv;
`ifdef CLASS_RESULT_MARGIN_EN
  assign bus.margin         = r_margin;
`endif
endmodule

// File: doc/class_result_unit.md
CLASS_RESULT_UNIT -- requirements
Module: class_result_unit

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of output classes (2..64).
REQ-002 SHALL have parameter SCORE_W, default 4, unsigned bits per class score (2..8).
REQ-003 SHALL have localparams IDX_W = $clog2(NUM_CLASSES) and COST_W = 2*SCORE_W + $clog2(NUM_CLASSES).
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have n_rst  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have start  input  1  one-cycle request to evaluate the current scores.
REQ-007 SHALL have scores  input  NUM_CLASSES*SCORE_W  flat score bus; class i occupies bits [i*SCORE_W +: SCORE_W].
REQ-008 SHALL have label_valid  input  1  the expected label is present at start.
REQ-009 SHALL have expected_label  input  NUM_CLASSES  target vector; bit i set means class i targets full scale.
REQ-010 SHALL have busy  output  1  scan in progress.
REQ-011 SHALL have done  output  1  one-cycle pulse when results update.
REQ-012 SHALL have detected_class  output  IDX_W  argmax index.
REQ-013 SHALL have max_score  output  SCORE_W  the winning score.
REQ-014 SHALL have cost  output  COST_W  squared-error cost.
REQ-015 SHALL have cost_valid  output  1  the cost output is meaningful.

Function
REQ-016 SHALL implement FSM IDLE->SCAN->DONE->IDLE.
REQ-017 IDLE: on start=1, SHALL capture scores, expected_label and label_valid into internal registers, clear the accumulators, set the class counter to 0, and enter SCAN.
REQ-018 SCAN: SHALL process exactly one class per cycle, counter 0..NUM_CLASSES-1, then enter DONE.
REQ-019 Argmax: a class SHALL replace the current best only if its score is strictly greater; ties SHALL resolve to the lowest index.
REQ-020 Cost term for class i SHALL be (t_i - s_i)^2, where t_i = 2^SCORE_W-1 if label bit i is set, else 0; the arithmetic is unsigned, uses the absolute difference, and accumulates without saturation in COST_W bits.
REQ-021 Multi-hot or all-zero expected_label SHALL be applied bitwise per REQ-020, with no error.
REQ-022 DONE: SHALL latch detected_class, max_score and cost to the outputs, set cost_valid = captured label_valid, assert done for exactly one cycle, and return to IDLE.
REQ-023 Latency from start to done SHALL be exactly NUM_CLASSES+1 cycles.
REQ-024 busy SHALL be 1 in SCAN and DONE and 0 in IDLE.
REQ-025 start while busy SHALL be ignored, with no queuing.
REQ-026 When label_valid=0 at capture, cost SHALL be output as 0 and cost_valid as 0.
REQ-027 Outputs SHALL hold their last results between scans, and changes to the scores or label inputs after capture SHALL have no effect.
REQ-028 start in the same cycle that DONE returns to IDLE SHALL be ignored; a new start is accepted from the following IDLE cycle.

Reset
REQ-029 n_rst=0 SHALL asynchronously force IDLE and busy=0, done=0, detected_class=0, max_score=0, cost=0, cost_valid=0.
REQ-030 Reset mid-SCAN SHALL abort the scan with no done pulse; the first start after release SHALL operate normally.

Configuration
REQ-031 Macro CLASS_RESULT_MARGIN_EN defined SHALL add output margin (SCORE_W bits) = max_score minus the runner-up score, updated in DONE and reset to 0.
REQ-032 The runner-up SHALL be the largest score among the remaining classes; an equal score at another index gives margin 0.
REQ-033 Macro undefined SHALL remove the margin port and its logic entirely, with all other behaviour identical.

Verification
REQ-034 Defaults; scores class0..9 = 1,2,3,15,4,0,0,0,0,0; label bit3 set, valid -> after 11 cycles done=1, detected_class=3, max_score=15, cost=1+4+9+0+16=30, cost_valid=1.
REQ-035 All scores 7, label_valid=0 -> detected_class=0, max_score=7, cost=0, cost_valid=0.
REQ-036 Second start pulsed at cycle 3 of a scan -> still a single done, at cycle 11 after the first start; results from the first capture.
REQ-037 n_rst asserted at cycle 5 of a scan -> outputs zero, no done; a restart with the REQ-034 vector reproduces the REQ-034 results.
REQ-038 NUM_CLASSES=16, SCORE_W=8, all scores 0, label all-ones -> cost=16*255^2=1040400, fitting COST_W=20, no overflow.
REQ-039 With CLASS_RESULT_MARGIN_EN, scores 9,12,12,3 at NUM_CLASSES=4 -> detected_class=1, margin=0; scores 2,10,5,1 -> margin=5.
